// File: rtl/uart_tx8.sv
// 8N1 UART transmitter that pops bytes from a registered-output FIFO and shifts them out LSB first.
// Define UART_TX8_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx8 #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clock_in,
  input  logic       reset_in,
  input  logic       enable_in,
  input  logic       fifo_readable_in,
  output logic       fifo_read_out,
  input  logic [7:0] fifo_rdata_in,
  output logic       tx_out,
  output logic       busy_out
);

  localparam logic [2:0]  S_IDLE   = 3'd0;
  localparam logic [2:0]  S_READ   = 3'd1;
  localparam logic [2:0]  S_FETCH  = 3'd2;
  localparam logic [2:0]  S_START  = 3'd3;
  localparam logic [2:0]  S_DATA   = 3'd4;
`ifdef UART_TX8_PARITY_EN
  localparam logic [2:0]  S_PARITY = 3'd5;
`endif
  localparam logic [2:0]  S_STOP   = 3'd6;
  localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);

  logic [2:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic        rd_q, rd_d;
  logic        busy_q, busy_d;
  logic        bit_end_s;
`ifdef UART_TX8_PARITY_EN
  logic        parity_q, parity_d;

  function automatic logic even_parity(input logic [7:0] data);
    return ^data;
  endfunction
`endif

  assign bit_end_s = (cnt_q == LAST_CNT);

  // Next-state, counter and shift-register logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
`ifdef UART_TX8_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (enable_in && fifo_readable_in) begin
          state_d = S_READ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        shift_d  = fifo_rdata_in;
        cnt_d    = 16'd0;
        idx_d    = 3'd0;
`ifdef UART_TX8_PARITY_EN
        parity_d = even_parity(fifo_rdata_in);
`endif
        state_d  = S_START;
      end
      S_START: begin
        if (bit_end_s) begin
          cnt_d   = 16'd0;
          state_d = S_DATA;
        end else begin
          cnt_d   = cnt_q + 16'd1;
        end
      end
      S_DATA: begin
        if (bit_end_s) begin
          cnt_d   = 16'd0;
          shift_d = {1'b0, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef UART_TX8_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            state_d = S_DATA;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
`ifdef UART_TX8_PARITY_EN
      S_PARITY: begin
        if (bit_end_s) begin
          cnt_d   = 16'd0;
          state_d = S_STOP;
        end else begin
          cnt_d   = cnt_q + 16'd1;
        end
      end
`endif
      S_STOP: begin
        if (bit_end_s) begin
          cnt_d   = 16'd0;
          state_d = S_IDLE;
        end else begin
          cnt_d   = cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so the registered pins line up with the state register.
  always_comb begin
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
`ifdef UART_TX8_PARITY_EN
      S_PARITY: tx_d = parity_d;
`endif
      default:  tx_d = 1'b1;
    endcase
    rd_d   = (state_d == S_READ);
    // Busy also covers the first IDLE cycle, so it drops only after the line has settled high.
    busy_d = (state_d != S_IDLE) || (state_q != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      state_q  <= S_IDLE;
      cnt_q    <= 16'd0;
      idx_q    <= 3'd0;
      shift_q  <= 8'd0;
      tx_q     <= 1'b1;
      rd_q     <= 1'b0;
      busy_q   <= 1'b0;
`ifdef UART_TX8_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      rd_q     <= rd_d;
      busy_q   <= busy_d;
`ifdef UART_TX8_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign fifo_read_out = rd_q;
  assign tx_out        = tx_q;
  assign busy_out      = busy_q;

endmodule

// File: tb/tb_uart_tx8.sv
// Scoreboard bench for uart_tx8: a FIFO model feeds bytes, a line monitor rebuilds each frame from the byte.
module tb_uart_tx8;
  localparam int CPB = 4;
`ifdef UART_TX8_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int PERIOD = FB * CPB + 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       readable;
  logic       rd;
  logic [7:0] rdata;
  logic       tx;
  logic       busy;

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  int n_frames = 0, n_strobes = 0;
  int busy_run = 0, last_busy_run = 0, hi_run = 0, last_gap = 0;

  uart_tx8 #(.CLKS_PER_BIT(CPB)) dut (
    .clock_in(clk), .reset_in(rst), .enable_in(en), .fifo_readable_in(readable),
    .fifo_read_out(rd), .fifo_rdata_in(rdata), .tx_out(tx), .busy_out(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  task automatic push_byte(input logic [7:0] b);
    fifo_q.push_back(b);
    readable = 1'b1;
  endtask

  // FIFO read side: one registered pop per strobe, the popped byte becomes the next expected frame.
  task automatic fifo_model();
    logic pop;
    logic [7:0] b;
    forever begin
      @(negedge clk);
      pop = rd && !rst;
      @(posedge clk);
      #1;
      if (pop) begin
        if (fifo_q.size() == 0) begin
          check("underflow_read", 1, 0);
        end else begin
          b = fifo_q.pop_front();
          rdata = b;
          exp_q.push_back(b);
        end
        readable = (fifo_q.size() != 0);
      end
    end
  endtask

  // Line monitor: on each start bit, pop the expected byte and compare the whole frame sample by sample.
  task automatic monitor();
    logic        in_frame = 1'b0;
    logic        prev_tx = 1'b1;
    logic [10:0] bits = '0;
    logic [7:0]  cur;
    int          k = 0, errs = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_frame = 1'b0;
        exp_q.delete();
        busy_run = 0;
        hi_run = 0;
        prev_tx = 1'b1;
      end else begin
        if (rd) n_strobes++;
        if (busy) busy_run++;
        else if (busy_run != 0) begin
          last_busy_run = busy_run;
          busy_run = 0;
        end
        if (!in_frame && tx == 1'b0 && prev_tx == 1'b1) begin
          last_gap = hi_run;
          hi_run = 0;
          if (exp_q.size() == 0) begin
            check("unexpected_frame", 1, 0);
            cur = 8'h00;
          end else begin
            cur = exp_q.pop_front();
          end
          bits = '1;
          bits[0] = 1'b0;
          for (int i = 0; i < 8; i++) bits[i+1] = cur[i];
          if (FB == 11) bits[9] = ($countones(cur) % 2 == 1);
          in_frame = 1'b1;
          k = 0;
          errs = 0;
        end
        if (in_frame) begin
          if (tx !== bits[k / CPB]) errs++;
          k++;
          if (k == FB * CPB) begin
            if (errs != 0) $display("FAIL frame byte 0x%02h: %0d wrong line samples", cur, errs);
            check("frame", errs, 0);
            n_frames++;
            in_frame = 1'b0;
            hi_run = 0;
          end
        end else if (tx) begin
          hi_run++;
        end
        prev_tx = tx;
      end
    end
  endtask

  task automatic wait_frames(input int target, input int budget);
    int c = 0;
    while (n_frames < target && c < budget) begin
      @(negedge clk);
      c++;
    end
    check("frame_timeout", n_frames >= target ? 1 : 0, 1);
    repeat (5) @(negedge clk);
  endtask

  initial begin
    int s0, f0, viol, c;
    rst = 1'b1; en = 1'b0; readable = 1'b0; rdata = 8'h00;
    fork
      fifo_model();
      monitor();
    join_none
    repeat (3) @(negedge clk);
    check("reset_tx", int'(tx), 1);
    check("reset_busy", int'(busy), 0);
    check("reset_read", int'(rd), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // single 0x55
    en = 1'b1; s0 = n_strobes; f0 = n_frames;
    push_byte(8'h55);
    wait_frames(f0 + 1, PERIOD + 50);
    check("single_strobes", n_strobes - s0, 1);
    check("single_busy_len", last_busy_run, PERIOD);

    // back-to-back 0xA5, 0x3C
    s0 = n_strobes; f0 = n_frames;
    push_byte(8'hA5);
    push_byte(8'h3C);
    wait_frames(f0 + 2, 2 * PERIOD + 50);
    check("b2b_strobes", n_strobes - s0, 2);
    check("b2b_gap", last_gap, 3);
    check("b2b_busy_len", last_busy_run, 2 * PERIOD);

    // empty FIFO with enable high
    s0 = n_strobes; viol = 0;
    repeat (200) begin
      @(negedge clk);
      if (rd || !tx || busy) viol++;
    end
    check("empty_idle", viol, 0);
    check("empty_strobes", n_strobes - s0, 0);

    // enable low holds a waiting byte; raising it starts a frame 3 cycles later
    en = 1'b0; viol = 0; f0 = n_frames;
    push_byte(8'h01);
    repeat (50) begin
      @(negedge clk);
      if (rd || !tx || busy) viol++;
    end
    check("disabled_idle", viol, 0);
    en = 1'b1; c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (tx && c < 20);
    check("enable_to_start", c, 3);
    wait_frames(f0 + 1, PERIOD + 50);

    // reset during data bit 3 of 0xFF
    f0 = n_frames;
    push_byte(8'hFF);
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (tx && c < 20);
    check("ff_start_seen", int'(tx), 0);
    repeat (4 * CPB + 1) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midreset_tx", int'(tx), 1);
    check("midreset_busy", int'(busy), 0);
    check("midreset_read", int'(rd), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("midreset_no_frame", n_frames - f0, 0);
    push_byte(8'($urandom_range(0, 255)));
    wait_frames(f0 + 1, PERIOD + 50);

    // random burst plus the parity reference bytes
    s0 = n_strobes; f0 = n_frames;
    for (int i = 0; i < 6; i++) push_byte(8'($urandom_range(0, 255)));
    push_byte(8'h07);
    push_byte(8'h03);
    wait_frames(f0 + 8, 8 * PERIOD + 100);
    check("burst_strobes", n_strobes - s0, 8);
    check("burst_busy_len", last_busy_run, 8 * PERIOD);

    check("fifo_drained", fifo_q.size(), 0);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
